// File: rtl/cpu_writeback.sv
// ---------------------------------------------------------------------------
// cpu_writeback
//
// Destination side of the CPU 8-bit data bus. The bus mux places one source on
// the bus; this block loads that value into the destination named by
// wb_select_i when wb_write_i is high. It holds register A, register B, the
// program counter and the output-port storage, and feeds the stored values
// back to the bus mux and the ALU. The output port reaches the display/IO
// through a valid/ready handshake.
//
// Build option:
//   CPU_WB_OUT_FIFO_EN  defined   -> output storage is an OUT_DEPTH-entry FIFO
//                       undefined -> output storage is one holding register
//
// Ports:
//   clk_i           system clock, rising edge
//   rst_i           synchronous active-high reset
//   wb_data_i       bus value to load
//   wb_select_i     destination: 0 none, 1 A, 2 B, 3 PC, 4 OUT, 5-7 none
//   wb_write_i      write strobe
//   pc_inc_i        increment PC (a same-cycle PC write wins)
//   reg_a_o/reg_b_o register A / register B
//   pc_o            program counter
//   out_data_o      output-port data (head of storage)
//   out_valid_o     out_data_o holds an undelivered value
//   out_ready_i     consumer accepts when out_valid_o && out_ready_i
//   out_full_o      storage full; an OUT write now is dropped unless popped
//   out_overflow_o  sticky: an OUT write was dropped
// ---------------------------------------------------------------------------
module cpu_writeback #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = 8'h00,
  parameter int                    OUT_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic [2:0]            wb_select_i,
  input  logic                  wb_write_i,
  input  logic                  pc_inc_i,
  output logic [DATA_WIDTH-1:0] reg_a_o,
  output logic [DATA_WIDTH-1:0] reg_b_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_full_o,
  output logic                  out_overflow_o
);

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_A    = 3'd1,
    SEL_B    = 3'd2,
    SEL_PC   = 3'd3,
    SEL_OUT  = 3'd4
  } wb_sel_e;

  // Reject unsupported buffer depths at elaboration time.
  if (OUT_DEPTH < 2 || OUT_DEPTH > 16 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cpu_writeback: OUT_DEPTH must be a power of two in 2..16");
  end

  // One-hot destination decode; reserved codes decode to nothing.
  logic wr_a, wr_b, wr_pc, push;
  assign wr_a  = wb_write_i && (wb_select_i == SEL_A);
  assign wr_b  = wb_write_i && (wb_select_i == SEL_B);
  assign wr_pc = wb_write_i && (wb_select_i == SEL_PC);
  assign push  = wb_write_i && (wb_select_i == SEL_OUT);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_a_o <= '0;
      reg_b_o <= '0;
      pc_o    <= PC_RESET;
    end else begin
      if (wr_a) reg_a_o <= wb_data_i;
      if (wr_b) reg_b_o <= wb_data_i;
      // A jump load wins over increment and is not itself incremented.
      if (wr_pc)         pc_o <= wb_data_i;
      else if (pc_inc_i) pc_o <= pc_o + 1'b1;
    end
  end

  logic pop, accept;
  assign pop    = out_valid_o && out_ready_i;
  // A full store still accepts when the head leaves in the same cycle.
  assign accept = push && (!out_full_o || pop);

  always_ff @(posedge clk_i) begin
    if (rst_i)                out_overflow_o <= 1'b0;
    else if (push && !accept) out_overflow_o <= 1'b1;
  end

`ifdef CPU_WB_OUT_FIFO_EN
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  logic [DATA_WIDTH-1:0] fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  // NOTE: the storage array is not reset; occupancy is tracked by the reset
  // pointers/count, and out_data_o is forced to zero while empty.
  always_ff @(posedge clk_i) begin
    if (accept) fifo_mem[wr_ptr] <= wb_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are PTR_W wide so they wrap modulo OUT_DEPTH on their own.
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid_o = (count != '0);
  assign out_full_o  = (count == CNT_W'(OUT_DEPTH));
  assign out_data_o  = out_valid_o ? fifo_mem[rd_ptr] : '0;
`else
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= wb_data_i;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign out_valid_o = hold_valid;
  assign out_full_o  = hold_valid;
  assign out_data_o  = hold_data;
`endif

endmodule

// File: doc/cpu_writeback.md
Name: cpu_writeback

Overview:
- Destination side of the CPU 8-bit data bus: the bus mux drives one source onto the bus; this block loads that bus value into the selected destination.
- Holds register A, register B, the program counter and an output-port register.
- Exposes the stored values back to the bus mux sources and the ALU.
- Presents the output register to the external display/IO via a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8, bus and register width.
- PC_RESET, 8'h00, PC value after reset.
- OUT_DEPTH, 4, output buffer depth; used only when CPU_WB_OUT_FIFO_EN is defined; power of two, 2..16.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- wb_data_i  input  DATA_WIDTH  bus value (mux_data_o of the bus mux).
- wb_select_i  input  3  destination code: 0 NONE, 1 REG_A, 2 REG_B, 3 PC, 4 OUT, 5-7 reserved (treated as NONE).
- wb_write_i  input  1  write strobe; the load happens only when this is high.
- pc_inc_i  input  1  increment PC this cycle.
- reg_a_o  output  DATA_WIDTH  register A.
- reg_b_o  output  DATA_WIDTH  register B.
- pc_o  output  DATA_WIDTH  program counter.
- out_data_o  output  DATA_WIDTH  output-port data.
- out_valid_o  output  1  out_data_o holds an undelivered value.
- out_ready_i  input  1  consumer accepts when out_valid_o && out_ready_i.
- out_full_o  output  1  output storage full; a write to OUT now would be dropped.
- out_overflow_o  output  1  sticky: a write to OUT was dropped.

Behaviour:
- Reset (rst_i high at a clock edge, overrides all other inputs):
  - reg_a_o=0, reg_b_o=0, pc_o=PC_RESET, out_data_o=0.
  - out_valid_o=0, out_full_o=0, out_overflow_o=0.
  - Output storage emptied.
  - Reset mid-transfer discards the pending output value.
- Write latency: one cycle. With wb_write_i=1 at edge N, the selected destination shows wb_data_i after edge N. Exactly one destination is written per cycle.
- Select 0 or 5-7, or wb_write_i=0: no register changes, except PC increment and output handshake.
- REG_A / REG_B: plain load.
- PC:
  - Jump load (write to PC) has priority over pc_inc_i in the same cycle; the loaded value is not incremented.
  - Otherwise pc_inc_i adds 1 modulo 2^DATA_WIDTH (8'hFF -> 8'h00, no flag).
- OUT, default build (single holding register):
  - Write when empty: store, out_valid_o=1 the next cycle.
  - Pop (out_valid_o && out_ready_i): out_valid_o=0 the next cycle unless a write occurs in the same cycle.
  - Write and pop in the same cycle while full: the new value is accepted and out_valid_o stays 1.
  - Write while full without a same-cycle pop: value dropped, out_overflow_o set and held until reset, stored value unchanged.
  - out_full_o equals out_valid_o in this build.
- out_ready_i with out_valid_o=0: no effect.
- out_data_o is stable while out_valid_o=1 and not popped. It is registered, with no combinational path from wb_data_i.
- All outputs are registered.

Optional Feature:
- Macro: CPU_WB_OUT_FIFO_EN.
- Defined:
  - Output storage is an OUT_DEPTH-entry FIFO with read/write pointers and an occupancy count 0..OUT_DEPTH.
  - out_data_o is the head entry, out_valid_o = count!=0, out_full_o = count==OUT_DEPTH.
  - Write while full with a same-cycle pop: accepted, count unchanged.
  - Write while full without a pop: dropped, out_overflow_o set.
  - Pointers wrap modulo OUT_DEPTH.
  - Values are delivered in write order.
- Not defined: single holding register as above; OUT_DEPTH is ignored.

Test Plan:
- Reset, then write REG_A=8'h3C, then REG_B=8'hA5 -> reg_a_o=8'h3C one cycle after the first write; reg_b_o=8'hA5 after the second; pc_o=0.
- pc_o=8'hFE, pc_inc_i for 2 cycles -> 8'hFF, then 8'h00. Next, PC write 8'h10 with pc_inc_i=1 -> pc_o=8'h10.
- out_ready_i=0, write OUT 8'h11 then OUT 8'h22 (default build) -> out_data_o=8'h11, out_valid_o=1, out_overflow_o=1. Then raise out_ready_i -> out_valid_o=0 the next cycle.
- Full holding register 8'h11: write OUT 8'h33 with out_ready_i=1 in the same cycle -> out_data_o=8'h33, out_valid_o=1, out_overflow_o=0.
- With CPU_WB_OUT_FIFO_EN and OUT_DEPTH=4: write 1,2,3,4 with ready=0 -> out_full_o=1. Write 5 -> overflow=1. Ready=1 for 4 cycles -> pops 1,2,3,4, then out_valid_o=0.
- Assert rst_i while out_valid_o=1 and reg_a_o=8'h3C -> every output is at its reset value the next cycle.
